ssd_scan_ctrl: RTL and testbench
================================

# ssd_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display on the PmodGYRO demo.
- Holds a double-buffered 16-bit display word and walks the four digits in turn.
- For each digit it drives the nibble (`digit_out`), the digit index (`control`) and the mode (`display_sel`) into `seven_seg_decoder`, and the active-low anode enables (`an`) to the board.
- New data is accepted at any time but committed only at a frame boundary, so a frame never mixes old and new digits.

## Interface

Parameters:
- `CLK_DIV`, 25000, clock cycles per digit slot (4 kHz digit rate at 100 MHz); legal range ≥ 2.
- `GUARD`, 16, anode-off cycles at the start of each digit slot (ghosting guard); legal range 0 ≤ GUARD < CLK_DIV.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `data_in`  in  16  display word; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `sel_in`  in  1  mode sampled with `data_in`: 1 = decimal, 0 = hex.
- `load`  in  1  single-cycle write strobe for `data_in`/`sel_in`.
- `ack`  out  1  one-cycle pulse when pending data is committed to the shadow register.
- `digit_out`  out  4  nibble to the decoder's `num_in`.
- `control`  out  2  current digit index, to the decoder's `control`.
- `display_sel`  out  1  committed mode, to the decoder's `display_sel`.
- `an`  out  4  anode enables, active-low, one-hot-low or all high.
- `frame_tick`  out  1  one-cycle pulse on the cycle digit index wraps 3→0.

## Operation

- Reset (`rst_n`=0 at an edge) values:
  - `cnt`=0, `digit`=0, `an`=4'b1111.
  - `digit_out`=0, `control`=0, `display_sel`=0.
  - `ack`=0, `frame_tick`=0.
  - shadow=16'h0000, pending=0, pending_valid=0.
  - Reset mid-frame discards pending data and restarts at digit 0, guard phase.
- Prescaler `cnt` counts 0..CLK_DIV-1 and wraps.
  - On wrap, `digit` increments modulo 4.
  - On wrap from 3→0, a frame boundary occurs.
- Phases within each slot, two-state FSM:
  - GUARD phase, `cnt` < GUARD: `an`=4'b1111.
  - ON phase, `cnt` ≥ GUARD: `an` has bit `digit` low, all others high.
  - GUARD=0: ON phase for the whole slot.
- `digit_out` = shadow[4*digit+3 : 4*digit]; `control` = `digit`. Both are registered and update on the same edge `digit` changes.
- Load path:
  - `load`=1 captures `data_in`/`sel_in` into pending and sets pending_valid.
  - A second load before commit overwrites pending; latest wins, no error.
- Commit happens on the frame-boundary edge when pending_valid=1:
  - shadow ← pending, `display_sel` ← pending sel.
  - pending_valid cleared, `ack`=1 for one cycle.
  - Digit 0 of the new frame already shows new data.
- `load` on the same edge as a commit: the commit uses the old pending value. The new value is captured into pending and pending_valid stays 1, so it commits at the next frame boundary.
- In hex mode the decoder forces "H" on digit 3; the controller still drives shadow[15:12] unchanged.

## Timing

- Digit slot is CLK_DIV cycles; frame is 4·CLK_DIV cycles.
- Load-to-display latency: 1 to 4·CLK_DIV+1 cycles, depending on frame position. `ack` marks the exact commit cycle.
- `frame_tick` and `ack` assert in the same cycle as the commit edge's outputs, i.e. the first cycle of digit 0.
- With GUARD ≥ 1, `digit_out`/`control` change only while all anodes are off.

## Configuration

- `SSD_LZB_EN` defined: leading-zero blanking in decimal mode.
  - Applies when `display_sel`=1.
  - Digits 3..1 output 4'hA (the decoder renders blank) when their nibble and all higher nibbles are 0.
  - Digit 0 is never blanked. Hex mode is unaffected.
  - `an` timing is unchanged.
- `SSD_LZB_EN` undefined: `digit_out` is always the raw shadow nibble.

## Test plan

All scenarios use CLK_DIV=8, GUARD=2.
- Reset: hold `rst_n`=0 for 3 cycles, release.
  - All reset values hold during reset.
  - First `an`=4'b1110 appears at cycle 2 after release; `an`=4'b1101 appears at cycle 10.
- Scan order: load 16'h1234 (hex).
  - After `ack`, `digit_out` sequence is 4,3,2,1 with `control` 0,1,2,3.
  - Each `an` low for exactly 6 cycles, preceded by 2 cycles of 4'b1111.
- Tear-free commit: load 16'hABCD mid-digit-1, then 16'h5678 before the boundary.
  - The current frame finishes with the old data.
  - One `ack` only; the next frame shows 8,7,6,5.
- Simultaneous load and boundary: pending 16'h1111, and load 16'h2222 exactly on the frame-boundary edge.
  - That frame shows 1111 with `ack`.
  - The following frame shows 2222 with a second `ack`.
- Mode: load 16'h0042 with `sel_in`=1.
  - `display_sel`=1 after commit.
  - With `SSD_LZB_EN`: `digit_out` 2,4,A,A.
  - Without: 2,4,0,0.
- Reset mid-frame during digit 2 with pending data: pending is discarded, scan restarts at digit 0, and no `ack` fires.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller with a double-buffered display word.
// Optional leading-zero blanking in decimal mode is compiled in with `define SSD_LZB_EN.
module ssd_scan_ctrl #(
  parameter int CLK_DIV = 25000,
  parameter int GUARD   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        sel_in,
  input  logic        load,
  output logic        ack,
  output logic [3:0]  digit_out,
  output logic [1:0]  control,
  output logic        display_sel,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  typedef enum logic {S_GUARD = 1'b0, S_ON = 1'b1} phase_e;

  phase_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]   digit_q, digit_d;
  logic [15:0]  shadow_q, shadow_d;
  logic         sel_q, sel_d;
  logic [15:0]  pend_q, pend_d;
  logic         pend_sel_q, pend_sel_d;
  logic         pend_valid_q, pend_valid_d;
  logic         wrap, boundary, commit;
  logic [3:0]   an_d;
  logic [3:0]   nib_d;

  logic [3:0] an_q, digit_out_q;
  logic [1:0] control_q;
  logic       ack_q, frame_tick_q;

  function automatic logic [3:0] pick_nibble(input logic [15:0] w, input logic s,
                                             input logic [1:0] d);
    logic [3:0] n;
    logic       blank;
    n     = w[{d, 2'b00} +: 4];
    blank = 1'b0;
`ifdef SSD_LZB_EN
    if (s) begin
      case (d)
        2'd3:    blank = (w[15:12] == 4'h0);
        2'd2:    blank = (w[15:8] == 8'h00);
        2'd1:    blank = (w[15:4] == 12'h000);
        default: blank = 1'b0;
      endcase
    end
`else
    blank = s & 1'b0;
`endif
    return blank ? 4'hA : n;
  endfunction

  // load is a fire-and-forget strobe (no ready): latest write wins, and ack
  // pulses on the single cycle the pending word is committed at a frame boundary.
  always_comb begin
    wrap         = (cnt_q == LAST);
    cnt_d        = wrap ? '0 : cnt_q + 1'b1;
    digit_d      = wrap ? digit_q + 2'd1 : digit_q;
    boundary     = wrap && (digit_q == 2'd3);
    commit       = boundary && pend_valid_q;
    shadow_d     = commit ? pend_q : shadow_q;
    sel_d        = commit ? pend_sel_q : sel_q;
    pend_d       = load ? data_in : pend_q;
    pend_sel_d   = load ? sel_in : pend_sel_q;
    pend_valid_d = load | (pend_valid_q & ~commit);
    state_d      = (cnt_d < GUARD_C) ? S_GUARD : S_ON;
    an_d         = (state_d == S_ON) ? ~(4'b0001 << digit_d) : 4'hF;
    nib_d        = pick_nibble(shadow_d, sel_d, digit_d);
  end

  // Outputs are computed from next-state values so they line up with cnt/digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_GUARD;
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      shadow_q     <= 16'h0000;
      sel_q        <= 1'b0;
      pend_q       <= 16'h0000;
      pend_sel_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      an_q         <= 4'hF;
      digit_out_q  <= 4'h0;
      control_q    <= 2'd0;
      ack_q        <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      pend_q       <= pend_d;
      pend_sel_q   <= pend_sel_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      digit_out_q  <= nib_d;
      control_q    <= digit_d;
      ack_q        <= commit;
      frame_tick_q <= boundary;
    end
  end

  assign an          = an_q;
  assign digit_out   = digit_out_q;
  assign control     = control_q;
  assign display_sel = sel_q;
  assign ack         = ack_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl at CLK_DIV=8, GUARD=2 (32-cycle frames).
// Expected words in the vector table depend on whether SSD_LZB_EN is defined.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        sel_in;
  logic        load;
  logic        ack;
  logic [3:0]  digit_out;
  logic [1:0]  control;
  logic        display_sel;
  logic [3:0]  an;
  logic        frame_tick;

  ssd_scan_ctrl #(.CLK_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .sel_in     (sel_in),
    .load       (load),
    .ack        (ack),
    .digit_out  (digit_out),
    .control    (control),
    .display_sel(display_sel),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] data;
    logic        sel;
    int          load_at;
    logic [15:0] exp_w;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cmp(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h (an,dout,ctl,sel,ft,ack)", name, cyc, act, exp);
    end
  endtask

  // Checks the outputs for the current cycle from the bench's own position count, then advances.
  task automatic check_cycle(input logic [15:0] w, input logic s, input logic ack_f);
    int pos, d, k;
    logic [3:0] exp_an;
    logic [1:0] d2;
    pos    = cyc % 32;
    d      = pos / 8;
    k      = pos % 8;
    d2     = d[1:0];
    exp_an = (k < 2) ? 4'hF : ~(4'b0001 << d2);
    cmp("scan", {an, digit_out, control, display_sel, frame_tick, ack},
        {exp_an, w[4*d +: 4], d2, s, (pos == 0 && cyc != 0), (pos == 0 && ack_f)});
    tick();
  endtask

  task automatic check_reset();
    cmp("reset", {an, digit_out, control, display_sel, frame_tick, ack},
        {4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
  endtask

  logic [15:0] cur_w;
  logic        cur_s;

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 5, 16'h1234};
    vecs[1] = '{16'hFFFF, 1'b0, 0, 16'hFFFF};
`ifdef SSD_LZB_EN
    vecs[2] = '{16'h0042, 1'b1, 20, 16'hAA42};
    vecs[3] = '{16'h0900, 1'b1, 30, 16'hA900};
    vecs[4] = '{16'h0000, 1'b1, 12, 16'hAAA0};
`else
    vecs[2] = '{16'h0042, 1'b1, 20, 16'h0042};
    vecs[3] = '{16'h0900, 1'b1, 30, 16'h0900};
    vecs[4] = '{16'h0000, 1'b1, 12, 16'h0000};
`endif
    vecs[5] = '{16'h0042, 1'b0, 7, 16'h0042};

    rst_n = 1'b0; load = 1'b0; data_in = 16'h0; sel_in = 1'b0;
    repeat (3) begin
      tick();
      check_reset();
    end
    rst_n = 1'b1;
    cyc   = 0;
    cur_w = 16'h0000;
    cur_s = 1'b0;
    repeat (32) check_cycle(cur_w, cur_s, 1'b0);

    // Table: load at a given frame offset, commit lands on the next boundary.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].load_at; j++) check_cycle(cur_w, cur_s, 1'b0);
      load = 1'b1; data_in = vecs[i].data; sel_in = vecs[i].sel;
      check_cycle(cur_w, cur_s, 1'b0);
      load = 1'b0;
      while (cyc % 32 != 0) check_cycle(cur_w, cur_s, 1'b0);
      cur_w = vecs[i].exp_w;
      cur_s = vecs[i].sel;
      repeat (32) check_cycle(cur_w, cur_s, 1'b1);
    end
    repeat (32) check_cycle(cur_w, cur_s, 1'b0);

    // Tear-free: two loads within one frame, only the latest commits, once.
    repeat (10) check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b1; data_in = 16'hABCD; sel_in = 1'b0;
    check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b0;
    repeat (9) check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b1; data_in = 16'h5678; sel_in = 1'b0;
    check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b0;
    while (cyc % 32 != 0) check_cycle(cur_w, cur_s, 1'b0);
    cur_w = 16'h5678; cur_s = 1'b0;
    repeat (32) check_cycle(cur_w, cur_s, 1'b1);
    repeat (32) check_cycle(cur_w, cur_s, 1'b0);

    // Load on the boundary edge itself while data is already pending.
    repeat (5) check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b1; data_in = 16'h1111;
    check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b0;
    while (cyc % 32 != 31) check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b1; data_in = 16'h2222;
    check_cycle(cur_w, cur_s, 1'b0);
    load = 1'b0;
    repeat (32) check_cycle(16'h1111, 1'b0, 1'b1);
    repeat (32) check_cycle(16'h2222, 1'b0, 1'b1);
    repeat (32) check_cycle(16'h2222, 1'b0, 1'b0);

    // Reset during digit 2 with a pending word: it must never commit.
    repeat (3) check_cycle(16'h2222, 1'b0, 1'b0);
    load = 1'b1; data_in = 16'hBEEF; sel_in = 1'b1;
    check_cycle(16'h2222, 1'b0, 1'b0);
    load = 1'b0;
    while (cyc % 32 != 18) check_cycle(16'h2222, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) begin
      tick();
      check_reset();
    end
    rst_n = 1'b1;
    cyc   = 0;
    repeat (64) check_cycle(16'h0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
